// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and default parameters for the fetch-stage program counter.
//   coper_t    : 3-bit control-op encoding driven by the decoder
//   pc_state_t : interrupt FSM states (RUN / ISR)
//   decode_op  : maps the raw 3-bit op onto coper_t (6 and 7 become SEQ)
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_OFF_W     = 8;
    localparam int DEF_STK_DEPTH = 8;
    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_INT_VEC   = 'h004;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_BR   = 3'd4,
        OP_RETI = 3'd5
    } coper_t;

    typedef enum logic {
        RUN = 1'b0,
        ISR = 1'b1
    } pc_state_t;

    function automatic coper_t decode_op(input logic [2:0] raw);
        if (raw > 3'd5) begin
            return OP_SEQ;
        end
        return coper_t'(raw);
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// Parametrised LIFO holding return addresses.
//   push_i / pop_i : request one push or one pop this cycle (never both)
//   din_i          : value to push
//   dout_o         : current top of stack (undefined when empty)
//   empty_o/full_o : derived from the registered stack pointer
//   ovf_o / udf_o  : push while full / pop while empty (request is dropped)
// ---------------------------------------------------------------------------
module ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W,
    parameter int DEPTH = DEF_STK_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o,
    output logic             udf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SP_W  = PTR_W + 1;  // sp counts 0..DEPTH inclusive

    logic [SP_W-1:0]  sp_q, sp_d;
    logic [SP_W-1:0]  sp_top;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (sp_q == '0);
    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign ovf_o   = push_i & full_o;
    assign udf_o   = pop_i & empty_o;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~push_i & ~empty_o;
    assign sp_top  = sp_q - SP_W'(1);
    assign dout_o  = mem_q[sp_top[PTR_W-1:0]];

    always_comb begin
        // NOTE: default assignment first so every path drives sp_d; no latch.
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            sp_q <= sp_d;
        end
    end

    // NOTE: storage is not reset; sp alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[sp_q[PTR_W-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Registered program counter for the fetch stage with return stack and
// single-level interrupt entry/exit.
//   en_i          : advance enable (0 = stall, all state held)
//   coper_i       : control op (coper_t), 6/7 behave as SEQ
//   br_taken_i    : branch condition for BR
//   branch_off_i  : signed branch offset
//   jump_addr_i   : absolute target for JMP/CALL
//   int_i         : level interrupt request
//   pc_o          : registered PC, drives instruction memory address
//   int_ack_o     : combinational accept pulse for the current cycle
//   in_isr_o      : FSM is in ISR
//   stk_empty_o / stk_full_o : return-stack status
//   err_o         : sticky overflow / underflow / RETI-outside-ISR
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int OFF_W     = DEF_OFF_W,
    parameter int STK_DEPTH = DEF_STK_DEPTH,
    parameter int RESET_VEC = DEF_RESET_VEC,
    parameter int INT_VEC   = DEF_INT_VEC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [2:0]        coper_i,
    input  logic              br_taken_i,
    input  logic [OFF_W-1:0]  branch_off_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              int_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              int_ack_o,
    output logic              in_isr_o,
    output logic              stk_empty_o,
    output logic              stk_full_o,
    output logic              err_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    pc_state_t         state_q, state_d;
    logic              err_q, err_d;

    coper_t                   op;
    logic signed [ADDR_W-1:0] off_sext;
    logic [ADDR_W-1:0]        pc_inc, nxt, push_data, stk_dout;
    logic                     push_req, pop_req, accept, reti_in_run;
    logic                     stk_empty, stk_full, stk_ovf, stk_udf;

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .din_i   (push_data),
        .dout_o  (stk_dout),
        .empty_o (stk_empty),
        .full_o  (stk_full),
        .ovf_o   (stk_ovf),
        .udf_o   (stk_udf)
    );

    // Next-PC selection, stack requests and interrupt acceptance.
    always_comb begin
        op          = decode_op(coper_i);
        off_sext    = $signed(branch_off_i);
        pc_inc      = pc_q + ADDR_W'(1);
        nxt         = pc_inc;
        push_req    = 1'b0;
        pop_req     = 1'b0;
        push_data   = pc_inc;
        reti_in_run = 1'b0;
        unique case (op)
            OP_JMP:  nxt = jump_addr_i;
            OP_CALL: begin
                nxt      = jump_addr_i;
                push_req = 1'b1;
            end
            OP_RET, OP_RETI: begin
                pop_req     = 1'b1;
                nxt         = stk_empty ? pc_inc : stk_dout;
                reti_in_run = (op == OP_RETI) && (state_q == RUN);
            end
            OP_BR:   nxt = br_taken_i ? pc_q + off_sext : pc_inc;
            default: ;
        endcase

        // Only ops that leave the stack alone may take an interrupt, so the
        // entry push never collides with a CALL push or a RET pop.
        accept = en_i && int_i && (state_q == RUN) && !stk_full &&
                 (op == OP_SEQ || op == OP_JMP || op == OP_BR);
        if (accept) begin
            push_req  = 1'b1;
            push_data = nxt;
        end
        push_req = push_req & en_i;
        pop_req  = pop_req & en_i;
    end

    // Register next-state.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        err_d   = err_q;
        if (en_i) begin
            pc_d  = accept ? ADDR_W'(INT_VEC) : nxt;
            err_d = err_q | stk_ovf | stk_udf | reti_in_run;
            if (accept) begin
                state_d = ISR;
            end else if (op == OP_RETI) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(RESET_VEC);
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign pc_o        = pc_q;
    assign int_ack_o   = accept;
    assign in_isr_o    = (state_q == ISR);
    assign stk_empty_o = stk_empty;
    assign stk_full_o  = stk_full;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Scoreboard bench: the driver applies one op per cycle, steps an abstract
// model (integer PC, queue stack, ISR/err bits) and queues the expected
// outputs; an independent monitor compares them after each clock edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int DEPTH   = 8;
    localparam int INT_VEC = 'h004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic [2:0]  coper_i = '0;
    logic        br_taken_i = 1'b0;
    logic [7:0]  branch_off_i = '0;
    logic [11:0] jump_addr_i = '0;
    logic        int_i = 1'b0;
    logic [11:0] pc_o;
    logic        int_ack_o, in_isr_o, stk_empty_o, stk_full_o, err_o;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .coper_i      (coper_i),
        .br_taken_i   (br_taken_i),
        .branch_off_i (branch_off_i),
        .jump_addr_i  (jump_addr_i),
        .int_i        (int_i),
        .pc_o         (pc_o),
        .int_ack_o    (int_ack_o),
        .in_isr_o     (in_isr_o),
        .stk_empty_o  (stk_empty_o),
        .stk_full_o   (stk_full_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit ack;
        bit isr;
        bit empty;
        bit full;
        bit err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    int          m_pc;
    bit          m_isr, m_err;
    logic [11:0] m_stk[$];

    localparam int SEQ = 0, JMP = 1, CALL = 2, RET = 3, BR = 4, RETI = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One enabled/stalled cycle: drive inputs, advance model, queue expectation.
    task automatic cyc(input int op, input bit tk, input int off, input int ja,
                       input bit intr, input bit en);
        exp_t e;
        int   o, nxt;
        bit   acc;
        @(posedge clk);
        #2;
        coper_i      = 3'(op);
        br_taken_i   = tk;
        branch_off_i = 8'(off);
        jump_addr_i  = 12'(ja);
        int_i        = intr;
        en_i         = en;
        acc          = 1'b0;
        if (en) begin
            o   = (op > 5) ? SEQ : op;
            nxt = m_pc + 1;
            case (o)
                JMP: nxt = ja;
                CALL: begin
                    nxt = ja;
                    if (m_stk.size() < DEPTH) m_stk.push_back(12'(m_pc + 1));
                    else m_err = 1'b1;
                end
                RET, RETI: begin
                    if (o == RETI && !m_isr) m_err = 1'b1;
                    if (m_stk.size() > 0) nxt = int'(m_stk.pop_back());
                    else begin
                        nxt   = m_pc + 1;
                        m_err = 1'b1;
                    end
                    if (o == RETI) m_isr = 1'b0;
                end
                BR: if (tk) nxt = m_pc + int'($signed(8'(off)));
                default: ;
            endcase
            nxt = nxt & 'hFFF;
            if (intr && !m_isr && (o == SEQ || o == JMP || o == BR) && m_stk.size() < DEPTH) begin
                acc = 1'b1;
                m_stk.push_back(12'(nxt));
                nxt   = INT_VEC;
                m_isr = 1'b1;
            end
            m_pc = nxt;
        end
        e.pc    = m_pc;
        e.ack   = acc;
        e.isr   = m_isr;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DEPTH);
        e.err   = m_err;
        sb.push_back(e);
    endtask

    // Asynchronous reset applied between clock edges; outputs must react at once.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en_i  = 1'b0;
        int_i = 1'b0;
        #1;
        check("rst_pc", 32'(pc_o), 32'h0);
        check("rst_ack", 32'(int_ack_o), 32'h0);
        check("rst_isr", 32'(in_isr_o), 32'h0);
        check("rst_empty", 32'(stk_empty_o), 32'h1);
        check("rst_full", 32'(stk_full_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        m_pc  = 0;
        m_isr = 1'b0;
        m_err = 1'b0;
        m_stk.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: ack sampled mid-cycle (combinational), state sampled after edge.
    initial begin
        exp_t e;
        logic ack_s;
        forever begin
            @(negedge clk);
            ack_s = int_ack_o;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc", 32'(pc_o), 32'(e.pc));
                check("int_ack", 32'(ack_s), 32'(e.ack));
                check("in_isr", 32'(in_isr_o), 32'(e.isr));
                check("stk_empty", 32'(stk_empty_o), 32'(e.empty));
                check("stk_full", 32'(stk_full_o), 32'(e.full));
                check("err", 32'(err_o), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Sequential, jump and wrap
        repeat (3) cyc(SEQ, 0, 0, 0, 0, 1);
        cyc(JMP, 0, 0, 'h0FF, 0, 1);
        cyc(JMP, 0, 0, 'hFFF, 0, 1);
        cyc(SEQ, 0, 0, 0, 0, 1);
        cyc(7, 0, 0, 'h123, 0, 1);

        // Branches: backward taken, not taken, forward with wrap
        cyc(JMP, 0, 0, 'h010, 0, 1);
        cyc(BR, 1, 'hFC, 0, 0, 1);
        cyc(JMP, 0, 0, 'h010, 0, 1);
        cyc(BR, 0, 'hFC, 0, 0, 1);
        cyc(JMP, 0, 0, 'hFF0, 0, 1);
        cyc(BR, 1, 'h7F, 0, 0, 1);

        // Call / return, full nesting, overflow, unwinding, underflow
        cyc(JMP, 0, 0, 'h050, 0, 1);
        cyc(CALL, 0, 0, 'h200, 0, 1);
        cyc(RET, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(CALL, 0, 0, 'h100 + i * 'h10, 0, 1);
        cyc(CALL, 0, 0, 'h300, 0, 1);
        repeat (DEPTH) cyc(RET, 0, 0, 0, 0, 1);
        cyc(RET, 0, 0, 0, 0, 1);
        cyc(SEQ, 0, 0, 0, 0, 1);

        // Reset in the middle of a call chain
        repeat (3) cyc(CALL, 0, 0, 'h400, 0, 1);
        do_reset();

        // Interrupt entry, held request in ISR, exit
        cyc(JMP, 0, 0, 'h030, 0, 1);
        cyc(SEQ, 0, 0, 0, 1, 1);
        cyc(SEQ, 0, 0, 0, 1, 1);
        cyc(SEQ, 0, 0, 0, 0, 1);
        cyc(RETI, 0, 0, 0, 0, 1);

        // Ineligible cycles: CALL/RET, stall, full stack
        cyc(CALL, 0, 0, 'h600, 1, 1);
        cyc(RET, 0, 0, 0, 1, 1);
        cyc(SEQ, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) cyc(CALL, 0, 0, 'h700 + i, 0, 1);
        cyc(SEQ, 0, 0, 0, 1, 1);
        cyc(RET, 0, 0, 0, 1, 1);
        cyc(SEQ, 0, 0, 0, 1, 1);
        cyc(RETI, 0, 0, 0, 0, 1);
        cyc(RETI, 0, 0, 0, 0, 1);
        do_reset();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cyc(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
